// File: rtl/alu_issue_queue.sv
// Issue queue feeding an external 8-bit combinational ALU; registers and hands off results.
// Optional result counter enabled by defining ALU_ISSUE_STATS_EN.
module alu_issue_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [2:0]               in_sel,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [2:0]               alu_sel,
  input  logic [WIDTH-1:0]         alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [WIDTH-1:0]         res_data,
  output logic [2:0]               res_sel,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [15:0]              op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_mem_q [DEPTH];
  logic [WIDTH-1:0] b_mem_q [DEPTH];
  logic [2:0]       s_mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic             res_valid_q;
  logic [WIDTH-1:0] res_data_q;
  logic [2:0]       res_sel_q;
  logic             push, pop, exec;

  assign exec     = (state_q == EXEC);
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = exec;

  // Occupancy: a push and a pop in the same cycle cancel out.
  always_comb begin
    count_d = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
  end

  // Packet storage; contents need no reset since the count gates reads.
  always_ff @(posedge clk) begin
    if (push) begin
      a_mem_q[wr_ptr_q] <= in_a;
      b_mem_q[wr_ptr_q] <= in_b;
      s_mem_q[wr_ptr_q] <= in_sel;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  // Sequencer next state: only registered occupancy is visible here.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (count_q != '0) state_d = EXEC;
      EXEC: state_d = HOLD;
      HOLD: begin
        if (res_ready) state_d = (count_q != '0) ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Result register captures the ALU output at the end of EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_sel_q   <= '0;
    end else if (exec) begin
      res_valid_q <= 1'b1;
      res_data_q  <= alu_out;
      res_sel_q   <= s_mem_q[rd_ptr_q];
    end else if (res_valid_q && res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign alu_a      = exec ? a_mem_q[rd_ptr_q] : '0;
  assign alu_b      = exec ? b_mem_q[rd_ptr_q] : '0;
  assign alu_sel    = exec ? s_mem_q[rd_ptr_q] : '0;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_sel    = res_sel_q;
  assign fifo_count = count_q;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] op_cnt_q;

  // Saturating count of delivered results.
  always_ff @(posedge clk) begin
    if (rst) op_cnt_q <= '0;
    else if (res_valid_q && res_ready && op_cnt_q != 16'hFFFF)
      op_cnt_q <= op_cnt_q + 16'd1;
  end

  assign op_count = op_cnt_q;
`else
  assign op_count = 16'h0000;
`endif

endmodule
